// File: rtl/counter_pkg.sv
// Shared encodings for the modulo counter: terminal-count modes and the
// two-state one-shot FSM.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

endpackage

// File: rtl/mod_counter_n.sv
// Up/down modulo-MODULUS counter with clear, clamped load and wrap /
// saturate / one-shot terminal behaviour. The done output is the FSM state.
module mod_counter_n
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter longint      MODULUS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] cnt,
  output logic             cout,
  output logic             done,
  output logic             at_max,
  output logic             at_min
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter_n: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("mod_counter_n: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             cout_nxt;
  logic             at_term;

  always_comb begin
    cnt_nxt   = cnt;
    cout_nxt  = 1'b0;
    state_nxt = state;
    at_term   = up ? (cnt == MAX_VAL) : (cnt == '0);
    if (clr) begin
      cnt_nxt   = '0;
      state_nxt = ST_COUNT;
    end else if (load) begin
      // Clamping keeps a non-power-of-2 range from ever holding an illegal value.
      cnt_nxt   = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      state_nxt = ST_COUNT;
    end else if (en && state == ST_COUNT) begin
      if (!at_term) begin
        cnt_nxt = up ? cnt + 1'b1 : cnt - 1'b1;
      end else begin
        cout_nxt = 1'b1;
        case (mode)
          MODE_SAT:     cnt_nxt = cnt;
          MODE_ONESHOT: state_nxt = ST_DONE;
          default:      cnt_nxt = up ? '0 : MAX_VAL;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      cout  <= 1'b0;
      state <= ST_COUNT;
    end else begin
      cnt   <= cnt_nxt;
      cout  <= cout_nxt;
      state <= state_nxt;
    end
  end

  assign done   = (state == ST_DONE);
  assign at_max = (cnt == MAX_VAL);
  assign at_min = (cnt == '0);

endmodule

// File: doc/mod_counter_n.md
# mod_counter_n

Parametrised synchronous up/down modulo counter with load, clear, and three terminal-count modes (wrap, saturate, one-shot). It generalises the fixed 4-bit free-running counter into a reusable counting/timing primitive. It serves as the standard counter for timers, baud dividers and cascaded counters in the combinational/sequential library. All state changes on the rising clock edge, except the asynchronous reset.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32
- MODULUS, 256, count range 0..MODULUS-1; legal range 2..2**WIDTH

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- clr  in  1  synchronous clear; cnt←0, done←0
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  load value; clamped to MODULUS-1
- en  in  1  count enable
- up  in  1  direction; 1 = increment, 0 = decrement
- mode  in  2  terminal behaviour; 00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
- cnt  out  WIDTH  current count, registered
- cout  out  1  terminal-event pulse, registered
- done  out  1  one-shot complete flag, registered
- at_max  out  1  high when cnt == MODULUS-1; decoded from registered cnt
- at_min  out  1  high when cnt == 0; decoded from registered cnt

## Operation
- Reset (rst_n low, asynchronous): cnt=0, cout=0, done=0 immediately, without waiting for a clock edge. Resulting flags: at_min=1, at_max=0.
- Priority per edge: clr > load > en > hold.
- clr: cnt←0, done←0, cout←0.
- load: cnt←min(load_val, MODULUS-1), done←0, cout←0.
- Terminal value depends on direction: MODULUS-1 when up=1, 0 when up=0.
- Terminal event: en=1, done=0, and cnt already at the terminal value for the current direction.
- Non-terminal count: cnt←cnt±1, computed at WIDTH bits, cout←0.
- Terminal event, by mode:
  - wrap: cnt←0 (up) or MODULUS-1 (down); cout←1.
  - saturate: cnt holds; cout←1 on every cycle the event recurs.
  - one-shot: cnt holds; cout←1; done←1.
- Two-state FSM, tracked by done:
  - COUNT (done=0) → DONE on a one-shot terminal event.
  - DONE → COUNT on clr or load.
  - In DONE, en is ignored and cnt holds.
- en=0 (no clr/load): cnt holds; cout←0.
- Changes to mode or up take effect on the same edge they are sampled. A direction change while cnt sits at the old terminal simply counts away from it.
- A non-power-of-2 MODULUS must never produce cnt ≥ MODULUS, including after load or down-wrap.

## Timing
- Count and load latency: one cycle from the sampled edge to the new cnt.
- cout is high for exactly the cycle following the event edge, aligned with the wrapped or held cnt. It stays asserted only if the event recurs.
- done rises on the same edge that cout pulses in one-shot mode. done stays high until clr, load, or reset.
- at_max and at_min update with cnt and have no extra latency.
- Reset deassertion is synchronised externally; the block has no reset synchroniser.

## Structure
- Package counter_pkg holds:
  - mode encodings MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10;
  - the COUNT/DONE state constants.
- Single module; no sub-module is needed. Terminal detection and next-count logic live in one combinational block feeding one registered block.
- Parameter legality is checked with elaboration-time assertions on WIDTH and MODULUS.

## Test plan
All scenarios use WIDTH=4, MODULUS=10.
- Wrap up: mode=00, up=1, en=1 from cnt=8 → cnt 9, 0, 1; cout=1 only in the cycle cnt=0; at_max=1 when cnt=9.
- Wrap down: mode=00, up=0, en=1 from cnt=1 → cnt 0, 9, 8; cout=1 only in the cycle cnt=9; cnt never reaches 10–15.
- Saturate: mode=01, up=1, en=1 for 4 cycles from cnt=8 → cnt 9, 9, 9, 9; cout 0, 1, 1, 1.
- One-shot: load 7, mode=10, up=1, en held high → cnt 8, 9, 9; done and cout rise together with the second 9.
  - Further en: cnt stays 9, cout=0, done=1.
  - clr: cnt=0, done=0.
- Load clamp and priority:
  - load_val=12 → cnt=9.
  - clr=1 and load=1 with load_val=5 → cnt=0.
  - load=1 and en=1 with load_val=3 → cnt=3.
- Async reset mid-count: cnt=6, pull rst_n low between edges → cnt=0, cout=0, done=0 before the next edge; counting resumes from 0 on the first edge after release.
